rect_motion_ctrl: RTL
=====================

Name: rect_motion_ctrl

Overview:
- Sequences the top-left position (X_POS, Y_POS) that feeds the rectangle/frame hit-test blocks on the 1280x1024 raster.
- Updates the position once per N frames, at the frame-end strobe, so the drawn box never tears mid-frame.
- Two move modes: manual (direction buttons) and autonomous (constant drift).
- Coordinates wrap modulo H/V, matching the wrap-around that the hit-test logic already draws.

Parameters:
- H, 1280, horizontal active pixels; X range 0..H-1
- V, 1024, vertical active lines; Y range 0..V-1
- X_INIT, 590, X_POS after reset
- Y_INIT, 462, Y_POS after reset
- STEP, 4, pixels moved per update per axis; legal 1..63
- FRAME_DIV, 1, update every FRAME_DIV frame-end strobes; legal 1..63
- LARGHEZZA, 100, box width; used only with RECT_BOUNCE_EN
- ALTEZZA, 100, box height; used only with RECT_BOUNCE_EN

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  asynchronous active-low reset
- FRAME_END  in  1  one-cycle pulse at the end of active video, synchronous to CLK
- ENABLE  in  1  0 freezes the position; strobes are still counted
- MODE  in  1  0 manual, 1 autonomous
- BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT  in  1 each  asynchronous buttons, active-high
- X_POS  out  11  current X
- Y_POS  out  11  current Y
- DIR_X  out  1  autonomous X direction: 1 = right/+, 0 = left/-
- DIR_Y  out  1  autonomous Y direction: 1 = down/+, 0 = up/-
- UPDATED  out  1  one-cycle pulse when a new position is committed

Behaviour:
- Reset (asynchronous, RST_N low):
  - X_POS=X_INIT, Y_POS=Y_INIT, DIR_X=1, DIR_Y=1, UPDATED=0.
  - Frame counter=0, pending flags=0, state IDLE.
  - Reset mid-sequence discards the in-flight update.
- Button input:
  - Each button passes through a 2-flop synchroniser.
  - A synchronised high sets a sticky pending bit (PU, PD, PL, PR).
  - Pending bits are cleared only in CAPTURE. A press of at least 2 CLK cycles anywhere in a frame is never lost.
- Frame counter:
  - Increments on FRAME_END while in IDLE.
  - When it reaches FRAME_DIV-1 and FRAME_END is high, it resets to 0 and the FSM leaves IDLE.
  - FRAME_END seen outside IDLE is ignored and not counted.
- FSM:
  - IDLE -> CAPTURE on the qualifying strobe.
  - CAPTURE: latch pending bits into move flags, clear pending (a press arriving in the same cycle re-sets its bit), -> MOVE_X.
  - MOVE_X: compute X, -> MOVE_Y.
  - MOVE_Y: compute Y, -> COMMIT.
  - COMMIT: write X_POS/Y_POS together, UPDATED=1 for this cycle only, -> IDLE.
  - Latency: strobe at cycle t gives new X_POS/Y_POS and UPDATED at t+4.
  - If ENABLE=0 in CAPTURE: pending bits are cleared, the position is unchanged, and UPDATED still pulses.
- Manual mode (MODE=0), per axis:
  - Exactly one of the opposing flags set: move STEP in that direction.
  - Both or neither set: no move on that axis.
  - DIR_X/DIR_Y are unchanged.
- Autonomous mode (MODE=1):
  - Each axis moves STEP in DIR_X/DIR_Y every update.
  - A captured single button sets the corresponding DIR, which applies to this same update.
  - Opposing pair pressed together: DIR unchanged.
- Arithmetic, 12-bit intermediate, wrap without bounce:
  - Plus: if X+STEP >= H then X+STEP-H, else X+STEP.
  - Minus: if X < STEP then X+H-STEP, else X-STEP.
  - Same rules for Y with V.
  - Outputs are always in range.
- MODE change takes effect at the next CAPTURE.

Optional Feature:
- RECT_BOUNCE_EN defined:
  - Autonomous mode reflects instead of wrapping. X is clamped to 0..H-LARGHEZZA and Y to 0..ALTEZZA-independent range 0..V-ALTEZZA.
  - Crossing a limit saturates the coordinate to that limit and toggles the axis DIR in the same COMMIT.
  - Manual mode saturates without a DIR change.
- RECT_BOUNCE_EN undefined: wrap rules only. LARGHEZZA/ALTEZZA are unused.

Test Plan:
- Reset release, no buttons, MODE=0, one FRAME_END -> UPDATED 4 cycles later, X_POS=590, Y_POS=462.
- MODE=0, BTN_RIGHT pulsed 3 cycles mid-frame, FRAME_END -> X_POS=594, Y_POS=462. Next frame with no press -> unchanged.
- MODE=1, DIR_X=1, X_POS=1278, STEP=4, FRAME_END -> X_POS=2. Separately, MODE=1, DIR_Y=0, Y_POS=1 -> Y_POS=1021.
- BTN_LEFT and BTN_RIGHT pressed in the same frame, MODE=0 -> X unchanged. BTN_UP also pressed -> Y_POS decreases by 4.
- FRAME_DIV=3, six FRAME_END strobes -> exactly two UPDATED pulses, on strobes 3 and 6. Extra strobe injected during MOVE_X -> ignored, count unaffected.
- RECT_BOUNCE_EN, MODE=1, X_POS=1178, DIR_X=1 -> X_POS=1180, DIR_X=0. RST_N low during MOVE_Y -> X_POS=590, Y_POS=462 immediately, UPDATED stays 0.

Source files
------------

// File: rtl/rect_motion_ctrl.sv
// rect_motion_ctrl: frame-synchronous top-left position sequencer for the box.
// Optional RECT_BOUNCE_EN: reflect at the box limits instead of wrapping.
module rect_motion_ctrl #(
   parameter int H         = 1280,
   parameter int V         = 1024,
   parameter int X_INIT    = 590,
   parameter int Y_INIT    = 462,
   parameter int STEP      = 4,
   parameter int FRAME_DIV = 1,
   parameter int LARGHEZZA = 100,
   parameter int ALTEZZA   = 100
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FRAME_END,
   input  logic        ENABLE,
   input  logic        MODE,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   output logic [10:0] X_POS,
   output logic [10:0] Y_POS,
   output logic        DIR_X,
   output logic        DIR_Y,
   output logic        UPDATED
);

`ifdef RECT_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif

   localparam logic [11:0] XLIM  = 12'(BOUNCE ? H - LARGHEZZA : H);
   localparam logic [11:0] YLIM  = 12'(BOUNCE ? V - ALTEZZA : V);
   localparam logic [11:0] STP   = 12'(STEP);
   localparam logic [5:0]  FLAST = 6'(FRAME_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, CAPTURE, MOVE_X, MOVE_Y, COMMIT
   } state_t;

   state_t      state, nstate;
   logic [3:0]  sync_a, sync_b;
   logic [3:0]  pend, mv;
   logic        en_r, mode_r;
   logic [5:0]  fcnt;
   logic [10:0] x_new;
   logic        dx_new;
   logic [11:0] xp, xm, yp, ym;
   logic [10:0] x_calc, y_calc;
   logic        dx_calc, dy_calc, dx_pick, dy_pick;

   // one step on an axis; bit 11 flags a limit hit (bounce only)
   function automatic logic [11:0] step_axis(
      input logic [10:0] p,
      input logic        up,
      input logic [11:0] lim
   );
      logic [11:0] q, s;
      logic        hit;
      q   = {1'b0, p};
      hit = 1'b0;
`ifdef RECT_BOUNCE_EN
      if (up) begin
         s = q + STP;
         if (s >= lim) begin
            s   = lim;
            hit = 1'b1;
         end
      end else if (q <= STP) begin
         s   = '0;
         hit = 1'b1;
      end else begin
         s = q - STP;
      end
`else
      if (up) begin
         s = q + STP;
         if (s >= lim) s = s - lim;
      end else if (q < STP) begin
         s = q + lim - STP;
      end else begin
         s = q - STP;
      end
`endif
      return {hit, 11'(s)};
   endfunction

   // two-flop synchronisers, bit order {up, down, left, right}
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
         sync_b <= sync_a;
      end
   end

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= nstate;
   end

   // next-state sequencing: one pass per qualifying strobe
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (FRAME_END && fcnt == FLAST) nstate = CAPTURE;
         CAPTURE: nstate = MOVE_X;
         MOVE_X:  nstate = MOVE_Y;
         MOVE_Y:  nstate = COMMIT;
         COMMIT:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // X candidate: manual net press or autonomous drift
   always_comb begin
      xp      = step_axis(X_POS, 1'b1, XLIM);
      xm      = step_axis(X_POS, 1'b0, XLIM);
      x_calc  = X_POS;
      dx_calc = DIR_X;
      dx_pick = DIR_X;
      if (mv[0] & ~mv[1]) dx_pick = 1'b1;
      else if (mv[1] & ~mv[0]) dx_pick = 1'b0;
      if (en_r & mode_r) begin
         x_calc  = dx_pick ? xp[10:0] : xm[10:0];
         dx_calc = dx_pick ^ (dx_pick ? xp[11] : xm[11]);
      end else if (en_r & (mv[0] ^ mv[1])) begin
         x_calc = mv[0] ? xp[10:0] : xm[10:0];
      end
   end

   // Y candidate: down is +, up is -
   always_comb begin
      yp      = step_axis(Y_POS, 1'b1, YLIM);
      ym      = step_axis(Y_POS, 1'b0, YLIM);
      y_calc  = Y_POS;
      dy_calc = DIR_Y;
      dy_pick = DIR_Y;
      if (mv[2] & ~mv[3]) dy_pick = 1'b1;
      else if (mv[3] & ~mv[2]) dy_pick = 1'b0;
      if (en_r & mode_r) begin
         y_calc  = dy_pick ? yp[10:0] : ym[10:0];
         dy_calc = dy_pick ^ (dy_pick ? yp[11] : ym[11]);
      end else if (en_r & (mv[2] ^ mv[3])) begin
         y_calc = mv[2] ? yp[10:0] : ym[10:0];
      end
   end

   // strobe counting, sticky presses, staged update and commit
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fcnt    <= '0;
         pend    <= '0;
         mv      <= '0;
         en_r    <= 1'b0;
         mode_r  <= 1'b0;
         x_new   <= 11'(X_INIT);
         dx_new  <= 1'b1;
         X_POS   <= 11'(X_INIT);
         Y_POS   <= 11'(Y_INIT);
         DIR_X   <= 1'b1;
         DIR_Y   <= 1'b1;
         UPDATED <= 1'b0;
      end else begin
         UPDATED <= 1'b0;
         if (state == CAPTURE) pend <= sync_b;
         else                  pend <= pend | sync_b;
         if (state == IDLE && FRAME_END)
            fcnt <= (fcnt == FLAST) ? '0 : fcnt + 6'd1;
         unique case (state)
            CAPTURE: begin
               mv     <= ENABLE ? pend : '0;
               en_r   <= ENABLE;
               mode_r <= MODE;
            end
            MOVE_X: begin
               x_new  <= x_calc;
               dx_new <= dx_calc;
            end
            MOVE_Y: begin
               X_POS   <= x_new;
               DIR_X   <= dx_new;
               Y_POS   <= y_calc;
               DIR_Y   <= dy_calc;
               UPDATED <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
